// File: rtl/register_file_pkg.sv
// Shared constants and helpers for the register_file bank: default geometry,
// address-width derivation and the single write-legality check.
package regfile_pkg;

   localparam int unsigned DEF_WIDTH = 32;
   localparam int unsigned DEF_DEPTH = 32;

   function automatic int unsigned addr_width(input int unsigned depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

   // One definition of "ignored write" keeps the store, bypass and wr_err consistent.
   function automatic bit is_writable(input int unsigned addr,
                                      input int unsigned depth,
                                      input bit          zero_reg);
      return (addr < depth) && !(zero_reg && (addr == 0));
   endfunction

endpackage

// File: rtl/register_file_if.sv
// Write/read/output-enable bundle for register_file; master drives, slave is the bank.
interface register_file_if #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned ADDR_W = 5
);
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [WIDTH-1:0]  wdata;
   logic              re_a;
   logic [ADDR_W-1:0] raddr_a;
   logic              re_b;
   logic [ADDR_W-1:0] raddr_b;
   logic              oe;
   logic [WIDTH-1:0]  rdata_a;
   logic [WIDTH-1:0]  rdata_b;
   logic              wr_err;

   modport master (
      output we, waddr, wdata, re_a, raddr_a, re_b, raddr_b, oe,
      input  rdata_a, rdata_b, wr_err
   );

   modport slave (
      input  we, waddr, wdata, re_a, raddr_a, re_b, raddr_b, oe,
      output rdata_a, rdata_b, wr_err
   );
endinterface

// File: rtl/register_file_reg_word.sv
// Single storage word: load-enabled register with asynchronous active-low clear.
module reg_word #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)  q <= '0;
      else if (load) q <= d;
   end

endmodule

// File: rtl/register_file.sv
// Multi-entry register bank: one synchronous write port, two registered read
// ports with load-enable hold, optional write bypass and hardwired zero entry.
module register_file
   import regfile_pkg::*;
#(
   parameter int unsigned WIDTH    = DEF_WIDTH,
   parameter int unsigned DEPTH    = DEF_DEPTH,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned BYPASS   = 1
) (
   input  logic          clock,
   input  logic          reset_n,
   register_file_if.slave bus
);

   localparam int unsigned ADDR_W = addr_width(DEPTH);

   logic [WIDTH-1:0] entry [DEPTH];
   logic [WIDTH-1:0] hold_a, hold_b;
   logic [WIDTH-1:0] val_a, val_b;
   logic             wr_ok;

   assign wr_ok = bus.we && is_writable(32'(bus.waddr), DEPTH, ZERO_REG != 0);

   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      if (ZERO_REG != 0 && i == 0) begin : g_zero
         assign entry[i] = '0;
      end else begin : g_word
         reg_word #(.WIDTH(WIDTH)) u_word (
            .clock   (clock),
            .reset_n (reset_n),
            .load    (wr_ok && (bus.waddr == ADDR_W'(i))),
            .d       (bus.wdata),
            .q       (entry[i])
         );
      end
   end

   function automatic logic [WIDTH-1:0] read_value(input logic [ADDR_W-1:0] a);
      if (32'(a) >= DEPTH)                            return '0;
      else if (ZERO_REG != 0 && a == '0)              return '0;
      else if (BYPASS != 0 && wr_ok && a == bus.waddr) return bus.wdata;
      else                                            return entry[a];
   endfunction

   always_comb begin
      val_a = read_value(bus.raddr_a);
      val_b = read_value(bus.raddr_b);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hold_a     <= '0;
         hold_b     <= '0;
         bus.wr_err <= 1'b0;
      end else begin
         if (bus.re_a) hold_a <= val_a;
         if (bus.re_b) hold_b <= val_b;
         bus.wr_err <= bus.we && !wr_ok;
      end
   end

   // Output gating is purely combinational so oe never disturbs held data.
   assign bus.rdata_a = bus.oe ? hold_a : '0;
   assign bus.rdata_b = bus.oe ? hold_b : '0;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: default bank plus BYPASS=0 and DEPTH=20 variants.
module tb_register_file;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   int   tests = 0;
   int   fails = 0;

   always #5 clock = ~clock;

   register_file_if #(.WIDTH(32), .ADDR_W(5)) bus0 ();
   register_file_if #(.WIDTH(32), .ADDR_W(5)) bus1 ();
   register_file_if #(.WIDTH(32), .ADDR_W(5)) bus2 ();

   register_file u0 (.clock(clock), .reset_n(reset_n), .bus(bus0.slave));
   register_file #(.BYPASS(0)) u1 (.clock(clock), .reset_n(reset_n), .bus(bus1.slave));
   register_file #(.DEPTH(20)) u2 (.clock(clock), .reset_n(reset_n), .bus(bus2.slave));

   typedef struct {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        re_a;
      logic [4:0]  raddr_a;
      logic        re_b;
      logic [4:0]  raddr_b;
      logic        oe;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
      logic        exp_err;
   } vec_t;

   vec_t vecs [15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_all();
      bus0.we = 1'b0; bus0.waddr = '0; bus0.wdata = '0; bus0.re_a = 1'b0; bus0.raddr_a = '0;
      bus0.re_b = 1'b0; bus0.raddr_b = '0; bus0.oe = 1'b1;
      bus1.we = 1'b0; bus1.waddr = '0; bus1.wdata = '0; bus1.re_a = 1'b0; bus1.raddr_a = '0;
      bus1.re_b = 1'b0; bus1.raddr_b = '0; bus1.oe = 1'b1;
      bus2.we = 1'b0; bus2.waddr = '0; bus2.wdata = '0; bus2.re_a = 1'b0; bus2.raddr_a = '0;
      bus2.re_b = 1'b0; bus2.raddr_b = '0; bus2.oe = 1'b1;
   endtask

   initial begin
      vecs[0]  = '{1'b1, 5'd5,  32'hACA6ACA6, 1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 32'h0,        32'h0,        1'b0};
      vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  1'b0, 5'd0,  1'b1, 32'hACA6ACA6, 32'h0,        1'b0};
      vecs[2]  = '{1'b1, 5'd5,  32'h12345678, 1'b0, 5'd5,  1'b0, 5'd0,  1'b1, 32'hACA6ACA6, 32'h0,        1'b0};
      vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b1, 5'd5,  1'b1, 32'hACA6ACA6, 32'h12345678, 1'b0};
      vecs[4]  = '{1'b1, 5'd7,  32'hEEA6EEA6, 1'b0, 5'd0,  1'b1, 5'd7,  1'b1, 32'hACA6ACA6, 32'hEEA6EEA6, 1'b0};
      vecs[5]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 32'hACA6ACA6, 32'hEEA6EEA6, 1'b1};
      vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b1, 5'd0,  1'b1, 32'h0,        32'h0,        1'b0};
      vecs[7]  = '{1'b1, 5'd0,  32'h11111111, 1'b1, 5'd0,  1'b0, 5'd0,  1'b1, 32'h0,        32'h0,        1'b1};
      vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b1, 5'd7,  1'b1, 32'hEEA6EEA6, 32'hEEA6EEA6, 1'b0};
      vecs[9]  = '{1'b1, 5'd3,  32'hAEA7AEA7, 1'b1, 5'd5,  1'b0, 5'd0,  1'b1, 32'h12345678, 32'hEEA6EEA6, 1'b0};
      vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  1'b0, 5'd0,  1'b1, 32'hAEA7AEA7, 32'hEEA6EEA6, 1'b0};
      vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 32'h0,        32'h0,        1'b0};
      vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 32'hAEA7AEA7, 32'hEEA6EEA6, 1'b0};
      vecs[13] = '{1'b1, 5'd31, 32'h31313131, 1'b0, 5'd0,  1'b1, 5'd31, 1'b1, 32'hAEA7AEA7, 32'h31313131, 1'b0};
      vecs[14] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 1'b1, 5'd30, 1'b1, 32'h31313131, 32'h0,        1'b0};

      idle_all();
      repeat (3) @(posedge clock);
      #1;
      check("reset_rdata_a", bus0.rdata_a, 32'h0);
      check("reset_rdata_b", bus0.rdata_b, 32'h0);
      check("reset_wr_err", {31'b0, bus0.wr_err}, 32'h0);

      @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 32; i++) begin
         @(negedge clock);
         bus0.re_a = 1'b1;
         bus0.raddr_a = 5'(i);
         @(posedge clock);
         #1;
         check($sformatf("post_reset_entry%0d", i), bus0.rdata_a, 32'h0);
      end

      for (int i = 0; i < 15; i++) begin
         @(negedge clock);
         bus0.we = vecs[i].we;       bus0.waddr = vecs[i].waddr;     bus0.wdata = vecs[i].wdata;
         bus0.re_a = vecs[i].re_a;   bus0.raddr_a = vecs[i].raddr_a;
         bus0.re_b = vecs[i].re_b;   bus0.raddr_b = vecs[i].raddr_b; bus0.oe = vecs[i].oe;
         @(posedge clock);
         #1;
         check($sformatf("vec%0d_rdata_a", i), bus0.rdata_a, vecs[i].exp_a);
         check($sformatf("vec%0d_rdata_b", i), bus0.rdata_b, vecs[i].exp_b);
         check($sformatf("vec%0d_wr_err", i), {31'b0, bus0.wr_err}, {31'b0, vecs[i].exp_err});
      end

      // oe toggles between edges with no new read
      @(negedge clock);
      bus0.we = 1'b0; bus0.re_b = 1'b0; bus0.re_a = 1'b1; bus0.raddr_a = 5'd3; bus0.oe = 1'b1;
      @(posedge clock);
      #1;
      check("oe_loaded", bus0.rdata_a, 32'hAEA7AEA7);
      @(negedge clock);
      bus0.re_a = 1'b0;
      bus0.oe = 1'b0;
      #1;
      check("oe_low", bus0.rdata_a, 32'h0);
      #1;
      bus0.oe = 1'b1;
      #1;
      check("oe_high_again", bus0.rdata_a, 32'hAEA7AEA7);

      // BYPASS=0: same-cycle read sees old contents
      @(negedge clock);
      bus1.we = 1'b1; bus1.waddr = 5'd7; bus1.wdata = 32'hEEA6EEA6; bus1.re_b = 1'b1; bus1.raddr_b = 5'd7;
      @(posedge clock);
      #1;
      check("nobypass_old", bus1.rdata_b, 32'h0);
      @(negedge clock);
      bus1.we = 1'b0;
      @(posedge clock);
      #1;
      check("nobypass_new", bus1.rdata_b, 32'hEEA6EEA6);

      // DEPTH=20: out-of-range write ignored, no aliasing
      @(negedge clock);
      bus2.we = 1'b1; bus2.waddr = 5'd5; bus2.wdata = 32'h55555555;
      @(negedge clock);
      bus2.waddr = 5'd25; bus2.wdata = 32'hFFFFFFFF;
      @(posedge clock);
      #1;
      check("oor_wr_err", {31'b0, bus2.wr_err}, 32'h1);
      @(negedge clock);
      bus2.we = 1'b0; bus2.re_a = 1'b1; bus2.raddr_a = 5'd25; bus2.re_b = 1'b1; bus2.raddr_b = 5'd5;
      @(posedge clock);
      #1;
      check("oor_read25", bus2.rdata_a, 32'h0);
      check("oor_entry5", bus2.rdata_b, 32'h55555555);
      check("oor_err_clear", {31'b0, bus2.wr_err}, 32'h0);
      @(negedge clock);
      bus2.raddr_a = 5'd9; bus2.re_b = 1'b0;
      bus2.we = 1'b1; bus2.waddr = 5'd19; bus2.wdata = 32'h19191919;
      @(posedge clock);
      #1;
      check("oor_no_alias9", bus2.rdata_a, 32'h0);
      check("top_entry_err", {31'b0, bus2.wr_err}, 32'h0);
      @(negedge clock);
      bus2.we = 1'b0; bus2.raddr_a = 5'd19; bus2.re_b = 1'b1; bus2.raddr_b = 5'd20;
      @(posedge clock);
      #1;
      check("top_entry19", bus2.rdata_a, 32'h19191919);
      check("read_addr20", bus2.rdata_b, 32'h0);

      // asynchronous reset between edges with a write and read pending
      @(negedge clock);
      bus0.we = 1'b1; bus0.waddr = 5'd9; bus0.wdata = 32'hDEADBEEF;
      bus0.re_a = 1'b1; bus0.raddr_a = 5'd3; bus0.oe = 1'b1;
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst_a", bus0.rdata_a, 32'h0);
      check("async_rst_b", bus0.rdata_b, 32'h0);
      @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      bus0.we = 1'b0; bus0.raddr_a = 5'd9; bus0.re_b = 1'b1; bus0.raddr_b = 5'd3;
      @(posedge clock);
      #1;
      check("async_rst_no_write", bus0.rdata_a, 32'h0);
      check("async_rst_cleared3", bus0.rdata_b, 32'h0);
      check("async_rst_err", {31'b0, bus0.wr_err}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
